// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: shifts parallel words out MSB first on a registered
// serial line x (idle level 1) and tracks how many "010" patterns the
// downstream serial pattern detector will report.
// Optional build macro TX_PARITY_EN appends one even-parity bit per frame.
module serial_pattern_tx #(
    parameter int W   = 8,
    parameter int GAP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         x,
    output logic         x_valid,
    output logic         busy,
    output logic         done,
    output logic [9:0]   pat_count
);

    localparam int MAXC = (W > GAP) ? W : GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);
    localparam logic [CW-1:0] LAST_GAP = CW'((GAP > 0) ? GAP - 1 : 0);

`ifdef TX_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PAR, ST_GAP} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ZERO, S_ONE, S_STORE} trk_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          x_n;
    logic          load;
    logic          frame_end;
    logic          hs;
    logic [W-2:0]  shreg;
    trk_t          trk, trk_n;
`ifdef TX_PARITY_EN
    logic          par;
`endif

    // Same next-state rules as the detector; S_STORE on 1 goes back to
    // S_IDLE, so overlapping "01010" is counted once.
    function automatic trk_t trk_next(input trk_t s, input logic b);
        case (s)
            S_IDLE:  trk_next = b ? S_IDLE : S_ZERO;
            S_ZERO:  trk_next = b ? S_ONE  : S_ZERO;
            S_ONE:   trk_next = b ? S_IDLE : S_STORE;
            S_STORE: trk_next = b ? S_IDLE : S_ZERO;
            default: trk_next = S_IDLE;
        endcase
    endfunction

    // Frame sequencing: frame_end marks a cycle in which a new word may be
    // accepted (idle, or the final cycle of the current frame).
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        x_n       = x;
        load      = 1'b0;
        frame_end = 1'b0;
        case (state)
            ST_IDLE: frame_end = 1'b1;
            ST_SHIFT: begin
                if (cnt == LAST_BIT) begin
`ifdef TX_PARITY_EN
                    state_n = ST_PAR;
                    x_n     = par;
`else
                    if (GAP > 0) begin
                        state_n = ST_GAP;
                        cnt_n   = '0;
                        x_n     = 1'b1;
                    end else begin
                        frame_end = 1'b1;
                    end
`endif
                end else begin
                    cnt_n = cnt + CW'(1);
                    x_n   = shreg[W-2];
                end
            end
`ifdef TX_PARITY_EN
            ST_PAR: begin
                if (GAP > 0) begin
                    state_n = ST_GAP;
                    cnt_n   = '0;
                    x_n     = 1'b1;
                end else begin
                    frame_end = 1'b1;
                end
            end
`endif
            ST_GAP: begin
                if (cnt == LAST_GAP) frame_end = 1'b1;
                else                 cnt_n = cnt + CW'(1);
            end
            default: state_n = ST_IDLE;
        endcase

        din_ready = frame_end & ~rst;
        hs        = din_valid & din_ready;

        if (frame_end) begin
            cnt_n = '0;
            if (hs) begin
                state_n = ST_SHIFT;
                x_n     = din[W-1];
                load    = 1'b1;
            end else begin
                state_n = ST_IDLE;
                x_n     = 1'b1;
            end
        end
    end

    // Control state and the registered serial line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            x     <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            x     <= x_n;
        end
    end

    // Word shift register; the MSB goes straight to x at load time.
    always_ff @(posedge clk) begin
        if (load) begin
            shreg <= din[W-2:0];
`ifdef TX_PARITY_EN
            par   <= ^din;
`endif
        end else if (state == ST_SHIFT) begin
            shreg <= shreg << 1;
        end
    end

    assign trk_n = trk_next(trk, x);

    // Shadow tracker follows the line every cycle, idle 1s included.
    always_ff @(posedge clk) begin
        if (rst) begin
            trk       <= S_IDLE;
            pat_count <= '0;
        end else begin
            trk <= trk_n;
            if (trk_n == S_STORE) pat_count <= pat_count + 10'd1;
        end
    end

`ifdef TX_PARITY_EN
    assign x_valid = (state == ST_SHIFT) || (state == ST_PAR);
    assign done    = (state == ST_PAR);
`else
    assign x_valid = (state == ST_SHIFT);
    assign done    = (state == ST_SHIFT) && (cnt == LAST_BIT);
`endif
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx (W=8, GAP=1).
module tb_serial_pattern_tx;

    localparam int W   = 8;
    localparam int GAP = 1;
`ifdef TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL = W + P + GAP;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         x;
    logic         x_valid;
    logic         busy;
    logic         done;
    logic [9:0]   pat_count;

    int tests = 0;
    int fails = 0;
    logic [1:0] sb[$];   // {expected x, expected done}

    serial_pattern_tx #(.W(W), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .x(x), .x_valid(x_valid), .busy(busy),
        .done(done), .pat_count(pat_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--)
            sb.push_back({w[i], (i == 0) && (P == 0)});
`ifdef TX_PARITY_EN
        sb.push_back({^w, 1'b1});
`endif
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy || sb.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < limit), 1);
    endtask

    // Called at a negedge in IDLE: one handshake, then run to idle.
    task automatic send_one(input logic [W-1:0] w);
        chk("send_ready", 32'(din_ready), 1);
        din = w;
        din_valid = 1'b1;
        push_frame(w);
        @(negedge clk);
        din_valid = 1'b0;
        wait_idle(4 * FL);
    endtask

    // Keeps din_valid high until n frames have been accepted.
    task automatic stream(input int n, input logic [W-1:0] w);
        int sent = 0;
        int guard = 0;
        din = w;
        din_valid = 1'b1;
        while (sent < n && guard < n * FL + 20) begin
            if (din_ready) begin
                push_frame(w);
                sent++;
            end
            @(negedge clk);
            guard++;
        end
        din_valid = 1'b0;
        chk("stream_sent", 32'(sent), 32'(n));
    endtask

    // Monitor: pops one expected bit per x_valid cycle.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (x_valid) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_bit: x=%0d done=%0d with empty scoreboard (t=%0t)", x, done, $time);
                end else begin
                    e = sb.pop_front();
                    chk("x_bit", 32'(x), 32'(e[1]));
                    chk("done_bit", 32'(done), 32'(e[0]));
                end
            end else if (rst === 1'b0) begin
                chk("done_idle", 32'(done), 0);
                chk("x_idle", 32'(x), 1);
            end
        end
    end

    initial begin
        logic xv[20];
        int first, last, zeros;

        // Reset with din_valid asserted
        rst = 1'b1;
        din_valid = 1'b1;
        din = 8'hA5;
        repeat (3) @(negedge clk);
        chk("rst_x", 32'(x), 1);
        chk("rst_x_valid", 32'(x_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pat", 32'(pat_count), 0);
        chk("rst_ready", 32'(din_ready), 0);
        din_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(din_ready), 1);
        chk("post_rst_busy", 32'(busy), 0);

        // Single word 4F: bits 0,1,0,0,1,1,1,1
        chk("idle_ready", 32'(din_ready), 1);
        din = 8'h4F;
        din_valid = 1'b1;
        push_frame(8'h4F);
        for (int i = 1; i <= FL + 1; i++) begin
            @(negedge clk);
            if (i == 1) begin
                din_valid = 1'b0;
                din = 8'h00;
            end
            chk("w1_busy", 32'(busy), 32'(i <= FL));
            chk("w1_ready", 32'(din_ready), 32'(i >= FL));
            chk("w1_pat", 32'(pat_count), 32'(i >= 4));
        end

        // 0101_0101: overlap not counted, +2
        send_one(8'h55);
        chk("w55_pat", 32'(pat_count), 3);

        // Back-to-back frames, handshake taken in the gap cycle
        din = 8'h4F;
        din_valid = 1'b1;
        begin
            int sent = 0;
            for (int c = 0; c < 20; c++) begin
                if (din_valid && din_ready) begin
                    push_frame(8'h4F);
                    sent++;
                end
                @(negedge clk);
                if (sent == 2) din_valid = 1'b0;
                xv[c] = x_valid;
            end
            chk("b2b_sent", 32'(sent), 2);
        end
        first = -1;
        last = -1;
        for (int c = 0; c < 20; c++) begin
            if (xv[c]) begin
                if (first < 0) first = c;
                last = c;
            end
        end
        zeros = 0;
        for (int c = 0; c < 20; c++)
            if (c > first && c < last && !xv[c]) zeros++;
        chk("b2b_gap_cycles", 32'(zeros), 1);
        wait_idle(4 * FL);
        chk("b2b_pat", 32'(pat_count), 5);

        // Reset while the 4th bit is on x
        chk("mid_ready", 32'(din_ready), 1);
        din = 8'h4F;
        din_valid = 1'b1;
        push_frame(8'h4F);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            din_valid = 1'b0;
        end
        chk("mid_pat_before", 32'(pat_count), 6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_x", 32'(x), 1);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_x_valid", 32'(x_valid), 0);
        chk("mid_done", 32'(done), 0);
        chk("mid_pat", 32'(pat_count), 0);
        sb.delete();
        repeat (12) @(negedge clk);
        chk("mid_pat_after", 32'(pat_count), 0);

        // Counter wrap: 1023 frames, then one more
        stream(1023, 8'h4F);
        wait_idle(4 * FL);
        chk("wrap_1023", 32'(pat_count), 1023);
        send_one(8'h4F);
        chk("wrap_0", 32'(pat_count), 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
